// File: rtl/xoodoo_pkg.sv
// Shared definitions for the XOODOO permutation scheduler.
//   STATE_W     : permutation state width (fixed for Xoodoo)
//   LANE_W      : lane width of the Xoodoo state
//   NUM_ROUNDS  : rounds performed by the shared core
//   sched_state_e : scheduler FSM state, 2-bit encoding
package xoodoo_pkg;

    localparam int unsigned STATE_W    = 384;
    localparam int unsigned LANE_W     = 32;
    localparam int unsigned NUM_ROUNDS = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } sched_state_e;

endpackage

// File: rtl/xoodoo_perm_sched_if.sv
// Bundle between the sponge/duplex front-ends, the scheduler and the permutation core.
//   req_valid/req_state/req_ready  : per-requester request channel (req_ready one-hot)
//   rsp_valid/rsp_ready/rsp_state  : per-requester response channel, shared state bus
//   core_start/core_state_in       : launch of the shared permutation core
//   core_done/core_state_out       : completion of the shared permutation core
//   busy, perm_count               : status
//   err_timeout                    : only when XOODOO_SCHED_TIMEOUT_EN is defined
// Modport slave is the scheduler's view, master is the environment's view.
interface xoodoo_perm_sched_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned CNT_W   = 16
) ();
    import xoodoo_pkg::*;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*STATE_W-1:0] req_state;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [NUM_REQ-1:0]         rsp_ready;
    logic [STATE_W-1:0]         rsp_state;
    logic                       core_start;
    logic [STATE_W-1:0]         core_state_in;
    logic                       core_done;
    logic [STATE_W-1:0]         core_state_out;
    logic                       busy;
    logic [CNT_W-1:0]           perm_count;
`ifdef XOODOO_SCHED_TIMEOUT_EN
    logic                       err_timeout;
`endif

    modport slave (
        input  req_valid, req_state, rsp_ready, core_done, core_state_out,
        output req_ready, rsp_valid, rsp_state, core_start, core_state_in, busy, perm_count
`ifdef XOODOO_SCHED_TIMEOUT_EN
        , output err_timeout
`endif
    );

    modport master (
        output req_valid, req_state, rsp_ready, core_done, core_state_out,
        input  req_ready, rsp_valid, rsp_state, core_start, core_state_in, busy, perm_count
`ifdef XOODOO_SCHED_TIMEOUT_EN
        , input err_timeout
`endif
    );

endinterface

// File: rtl/xoodoo_rr_pick.sv
// Combinational round-robin pick, reusable for any shared resource.
//   i_req     : request vector
//   i_last    : index granted last time; search starts at i_last+1 and wraps
//   o_valid   : at least one request present
//   o_idx     : winning index (0 when o_valid is low)
module xoodoo_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    int unsigned      w_cand;
    logic [IDX_W-1:0] w_cand_idx;

    always_comb begin
        o_valid    = 1'b0;
        o_idx      = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand     = (32'(i_last) + k) % NUM_REQ;
            w_cand_idx = w_cand[IDX_W-1:0];
            if (!o_valid && i_req[w_cand_idx]) begin
                o_valid = 1'b1;
                o_idx   = w_cand_idx;
            end
        end
    end

endmodule

// File: rtl/xoodoo_perm_sched.sv
// Round-robin scheduler sharing one XOODOO permutation core between NUM_REQ requesters.
// A granted state is launched into the core; the core result is returned to its owner
// over a valid/ready handshake.
//   i_clk    : clock
//   i_resetn : asynchronous active-low reset
//   io_bus   : request, response, core and status signals (xoodoo_perm_sched_if.slave)
// Optional build macro XOODOO_SCHED_TIMEOUT_EN adds a WAIT watchdog and err_timeout.
module xoodoo_perm_sched
    import xoodoo_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_resetn,
    xoodoo_perm_sched_if.slave io_bus
);

    localparam int unsigned      IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    sched_state_e       r_state, w_state_d;
    logic [IDX_W-1:0]   r_last_grant, r_owner;
    logic [STATE_W-1:0] r_core_state_in, r_rsp_state;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [CNT_W-1:0]   r_perm_count;

    logic               w_grant_valid;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic [STATE_W-1:0] w_req_state_sel;
    logic               w_capture, w_done_take, w_handshake, w_timeout;

`ifdef XOODOO_SCHED_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 64;
    logic [6:0] r_to_cnt;
    logic       r_err_timeout;
`endif

    xoodoo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (io_bus.req_valid),
        .i_last  (r_last_grant),
        .o_valid (w_grant_valid),
        .o_idx   (w_grant_idx)
    );

    assign w_req_state_sel = io_bus.req_state[w_grant_idx*STATE_W +: STATE_W];
    assign w_owner_oh      = NUM_REQ'(1) << r_owner;

    always_comb begin
        w_state_d   = r_state;
        w_req_ready = '0;
        w_capture   = 1'b0;
        w_done_take = 1'b0;
        w_handshake = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_req_ready[w_grant_idx] = 1'b1;
                    w_capture                = 1'b1;
                    w_state_d                = LAUNCH;
                end
            end
            LAUNCH: w_state_d = WAIT;
            WAIT: begin
                if (io_bus.core_done) begin
                    w_done_take = 1'b1;
                    w_state_d   = RESP;
                end
`ifdef XOODOO_SCHED_TIMEOUT_EN
                else if (r_to_cnt == 7'(TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_state_d = IDLE;
                end
`endif
            end
            RESP: begin
                // Only the owner's ready bit completes the response.
                if (io_bus.rsp_ready[r_owner]) begin
                    w_handshake = 1'b1;
                    w_state_d   = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_last_grant    <= LAST_RST;
            r_owner         <= '0;
            r_core_state_in <= '0;
            r_rsp_state     <= '0;
            r_rsp_valid     <= '0;
            r_perm_count    <= '0;
        end else begin
            if (w_capture) begin
                r_core_state_in <= w_req_state_sel;
                r_owner         <= w_grant_idx;
            end
            if (w_done_take) begin
                r_rsp_state <= io_bus.core_state_out;
                r_rsp_valid <= w_owner_oh;
                if (~&r_perm_count) begin
                    r_perm_count <= r_perm_count + CNT_W'(1);
                end
            end
            if (w_handshake) begin
                r_rsp_valid  <= '0;
                r_last_grant <= r_owner;
            end
            // An abandoned permutation still counts as the owner's turn.
            if (w_timeout) begin
                r_last_grant <= r_owner;
            end
        end
    end

`ifdef XOODOO_SCHED_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_timeout;
            if (r_state == LAUNCH) begin
                r_to_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_to_cnt <= r_to_cnt + 7'd1;
            end
        end
    end

    assign io_bus.err_timeout = r_err_timeout;
`endif

    assign io_bus.req_ready     = w_req_ready;
    assign io_bus.rsp_valid     = r_rsp_valid;
    assign io_bus.rsp_state     = r_rsp_state;
    assign io_bus.core_start    = (r_state == LAUNCH);
    assign io_bus.core_state_in = r_core_state_in;
    assign io_bus.busy          = (r_state != IDLE);
    assign io_bus.perm_count    = r_perm_count;

endmodule
